// File: rtl/profile_sampler.sv
// profile_sampler: custom-instruction controller for the profiling counter block; owns the
//   12-bit counter control word and periodically snapshots masked counters into a sample FIFO.
// Latency: done/result are combinational in the start cycle; a sample is poppable the cycle after its push.
// Backpressure: none toward the instruction bus; a push into a full FIFO is dropped and sets sticky overflow.
// Ports: clock, reset (async, active-high); start/ciN/valueA/valueB -> done/result custom-instruction bus;
//   ctrlWord = counter control ([3:0] enable, [7:4] disable, [11:8] one-cycle reset pulse);
//   counterSel -> counter read mux, counterValue <- selected counter (same cycle).
// Option: define PROFILE_SAMPLER_TIMESTAMP_EN to start every round with a free-running cycle-count entry.
module profile_sampler #(
  parameter logic [7:0] customId   = 8'h00,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic [11:0] ctrlWord,
  output logic [1:0]  counterSel,
  input  logic [31:0] counterValue
);
  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;

  localparam logic [3:0] OP_WRCTRL = 4'd0;
  localparam logic [3:0] OP_PERIOD = 4'd1;
  localparam logic [3:0] OP_MASK   = 4'd2;
  localparam logic [3:0] OP_POP    = 4'd3;
  localparam logic [3:0] OP_STATUS = 4'd4;
  localparam logic [3:0] OP_CLEAR  = 4'd5;

  logic [1:0]       state;
  logic [31:0]      period;
  logic [31:0]      timer;
  logic [3:0]       mask;
  logic [3:0]       pending;     // mask bits of the current round not yet sampled
  logic [7:0]       ctrlHold;
  logic [3:0]       ctrlPulse;
  logic [34:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [4:0]       count;
  logic             overflow;

  logic [3:0]  opcode;
  logic        empty;
  logic        full;
  logic        doClear;
  logic        doPop;
  logic        doPush;
  logic        dropPush;
  logic        pushVld;
  logic [34:0] pushDat;
  logic        roundEnd;
  logic [1:0]  lowIdx;
  logic [3:0]  pendingNext;
  logic [34:0] headDat;
  logic        headTs;
  logic [1:0]  headTag;
  logic        unusedOpBits;

`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
  logic        tsPhase;          // first cycle of a round pushes the timestamp
  logic [31:0] cycleCount;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycleCount <= 32'd0;
    else       cycleCount <= cycleCount + 32'd1;
  end
`endif

  assign opcode       = valueA[3:0];
  assign unusedOpBits = ^valueA[31:4];
  assign done         = start && (ciN == customId);

  assign empty    = (count == 5'd0);
  assign full     = (count == DEPTH_CNT);
  assign doClear  = done && (opcode == OP_CLEAR);
  assign doPop    = done && (opcode == OP_POP) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign doPush   = pushVld && !doClear && (!full || doPop);
  assign dropPush = pushVld && !doClear && full && !doPop;

  assign headDat = fifoMem[rdPtr];
  assign headTs  = !empty && headDat[34];
  assign headTag = empty ? 2'd0 : headDat[33:32];

  // Lowest set bit of the remaining round mask gives the ascending walk order.
  always_comb begin
    lowIdx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) lowIdx = 2'(i);
    end
  end
  assign pendingNext = pending & ~(4'b0001 << lowIdx);

  always_comb begin
    counterSel = 2'd0;
    pushVld    = 1'b0;
    pushDat    = '0;
    roundEnd   = 1'b0;
    if (state == SAMPLE) begin
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
      if (tsPhase) begin
        pushVld  = 1'b1;
        pushDat  = {1'b1, 2'b00, cycleCount};
        roundEnd = (pending == 4'd0);
      end else
`endif
      begin
        counterSel = lowIdx;
        pushVld    = |pending;  // an empty latched mask still spends one cycle here
        pushDat    = {1'b0, lowIdx, counterValue};
        roundEnd   = (pendingNext == 4'd0);
      end
    end
  end

  always_comb begin
    result = 32'd0;
    if (done) begin
      case (opcode)
        OP_POP:    result = empty ? 32'd0 : headDat[31:0];
        OP_STATUS: result = {19'd0, headTs, headTag, state, overflow, full, empty, count};
        default:   result = 32'd0;
      endcase
    end
  end

  // Reset bits are a pulse: they follow valueB only in the cycle after WRCTRL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrlHold  <= 8'd0;
      ctrlPulse <= 4'd0;
    end else begin
      ctrlPulse <= (done && opcode == OP_WRCTRL) ? valueB[11:8] : 4'd0;
      if (done && opcode == OP_WRCTRL) ctrlHold <= valueB[7:0];
    end
  end
  assign ctrlWord = {ctrlPulse, ctrlHold};

  always_ff @(posedge clock) begin
    if (doPush) fifoMem[wrPtr] <= pushDat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else if (doClear) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (dropPush) overflow <= 1'b1;
    end
  end

  // PERIOD overrides whatever the sampler was doing, including a round in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      period  <= 32'd0;
      timer   <= 32'd0;
      mask    <= 4'd0;
      pending <= 4'd0;
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
      tsPhase <= 1'b0;
`endif
    end else begin
      if (done && opcode == OP_MASK) mask <= valueB[3:0];
      if (done && opcode == OP_PERIOD) begin
        period  <= valueB;
        pending <= 4'd0;
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
        tsPhase <= 1'b0;
`endif
        if (valueB != 32'd0) begin
          state <= WAIT;
          timer <= valueB - 32'd1;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          WAIT: begin
            if (timer == 32'd0) begin
              state   <= SAMPLE;
              pending <= mask;
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
              tsPhase <= 1'b1;
`endif
            end else begin
              timer <= timer - 32'd1;
            end
          end
          SAMPLE: begin
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
            if (tsPhase) tsPhase <= 1'b0;
            else
`endif
            pending <= pendingNext;
            if (roundEnd) begin
              state <= WAIT;
              timer <= period - 32'd1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_profile_sampler.sv
module tb_profile_sampler;
  localparam int         DEPTH = 16;
  localparam logic [7:0] CID   = 8'h00;
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif
  localparam int M_IDLE = 0, M_WAIT = 1, M_SAMPLE = 2;
  localparam int NO_PUSH = -2, TS_ITEM = -1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] valueA = 32'd0;
  logic [31:0] valueB = 32'd0;
  logic        done;
  logic [31:0] result;
  logic [11:0] ctrlWord;
  logic [1:0]  counterSel;
  logic [31:0] counterValue;
  logic [31:0] cvTable [4];

  assign counterValue = cvTable[counterSel];

  profile_sampler #(.customId(CID), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
    .done(done), .result(result), .ctrlWord(ctrlWord), .counterSel(counterSel),
    .counterValue(counterValue)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: FIFO as a queue, a round as a queue of scheduled sample items.
  logic [34:0] mFifo[$];
  int          mRound[$];
  int          mMode;
  int          mWait;
  logic [31:0] mPeriod;
  logic [3:0]  mMask;
  logic [7:0]  mHold;
  logic [3:0]  mPulse;
  logic        mOvf;
  logic [31:0] mCycle;
  logic [31:0] lastResult;
  logic [11:0] lastCtrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mReset();
    mFifo.delete();
    mRound.delete();
    mMode = M_IDLE; mWait = 0; mPeriod = 0; mMask = 0;
    mHold = 0; mPulse = 0; mOvf = 0; mCycle = 0;
  endtask

  function automatic logic [31:0] mStatus();
    logic [34:0] h = '0;
    if (mFifo.size() > 0) h = mFifo[0];
    return {19'd0, h[34], h[33:32], 2'(mMode), mOvf, mFifo.size() == DEPTH,
            mFifo.size() == 0, 5'(mFifo.size())};
  endfunction

  // Called at a falling edge: drive, compare, advance the model, move to the next falling edge.
  task automatic cyc(input bit st, input logic [7:0] ci, input logic [31:0] a, input logic [31:0] b);
    bit          d;
    logic [3:0]  op;
    int          item;
    bit          hasPush;
    logic [34:0] pushEnt;
    logic [31:0] expRes;
    start = st; ciN = ci; valueA = a; valueB = b;
    #1;
    d       = st && (ci == CID);
    op      = a[3:0];
    item    = (mMode == M_SAMPLE) ? mRound[0] : NO_PUSH;
    hasPush = (item != NO_PUSH);
    pushEnt = '0;
    if (item == TS_ITEM) pushEnt = {1'b1, 2'b00, mCycle};
    else if (item >= 0)  pushEnt = {1'b0, 2'(item), cvTable[item]};
    expRes = 32'd0;
    if (d && op == 4'd3 && mFifo.size() > 0) expRes = mFifo[0][31:0];
    if (d && op == 4'd4) expRes = mStatus();
    chk("done", {31'd0, done}, {31'd0, d});
    chk("result", result, expRes);
    chk("ctrlWord", {20'd0, ctrlWord}, {20'd0, mPulse, mHold});
    chk("counterSel", {30'd0, counterSel}, (item >= 0) ? item : 0);
    lastResult = result;
    lastCtrl   = ctrlWord;

    mPulse = (d && op == 4'd0) ? b[11:8] : 4'd0;
    if (d && op == 4'd0) mHold = b[7:0];
    if (d && op == 4'd5) begin
      mFifo.delete();
      mOvf = 1'b0;
    end else begin
      if (d && op == 4'd3 && mFifo.size() > 0) void'(mFifo.pop_front());
      if (hasPush) begin
        if (mFifo.size() < DEPTH) mFifo.push_back(pushEnt);
        else mOvf = 1'b1;
      end
    end
    if (mMode == M_SAMPLE) begin
      void'(mRound.pop_front());
      if (mRound.size() == 0) begin
        mMode = M_WAIT;
        mWait = int'(mPeriod);
      end
    end else if (mMode == M_WAIT) begin
      mWait--;
      if (mWait == 0) begin
        mMode = M_SAMPLE;
        if (TS != 0) mRound.push_back(TS_ITEM);
        for (int i = 0; i < 4; i++) if (mMask[i]) mRound.push_back(i);
        if (mRound.size() == 0) mRound.push_back(NO_PUSH);
      end
    end
    if (d && op == 4'd1) begin
      mPeriod = b;
      mRound.delete();
      if (b != 32'd0) begin
        mMode = M_WAIT;
        mWait = int'(b);
      end else begin
        mMode = M_IDLE;
      end
    end
    if (d && op == 4'd2) mMask = b[3:0];
    mCycle = mCycle + 32'd1;
    @(negedge clock);
  endtask

  task automatic op(input int code, input logic [31:0] b);
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_FFF0) | 32'(code);
    cyc(1'b1, CID, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, CID, $urandom(), $urandom());
  endtask

  task automatic doReset();
    reset = 1'b1; start = 1'b0;
    #1;
    chk("rst_ctrlWord", {20'd0, ctrlWord}, 32'd0);
    chk("rst_counterSel", {30'd0, counterSel}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mReset();
  endtask

  initial begin
    bit          st;
    logic [7:0]  ci;
    int          k;
    int          code;
    logic [31:0] b;
    bit          popHeavy;
    cvTable[0] = 32'hAA; cvTable[1] = 32'hBB; cvTable[2] = 32'hCC; cvTable[3] = 32'hDD;
    mReset();
    @(negedge clock);
    doReset();

    op(4, 0);
    chk("status_after_reset", lastResult, 32'h020);
    chk("ctrl_after_reset", {20'd0, lastCtrl}, 32'd0);

    op(0, 32'h101);
    idle(1);
    chk("wrctrl_pulse", {20'd0, lastCtrl}, 32'h101);
    idle(1);
    chk("wrctrl_held", {20'd0, lastCtrl}, 32'h001);

    op(2, 32'h3);
    op(1, 32'd4);
    idle(4 + 2 + TS);
    op(1, 32'd0);
    op(4, 0);
    chk("round_count", {27'd0, lastResult[4:0]}, 32'(2 + TS));
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
    chk("round_head_is_ts", {31'd0, lastResult[12]}, 32'd1);
    op(3, 0);
`endif
    op(3, 0);
    chk("pop_first", lastResult, 32'hAA);
    op(3, 0);
    chk("pop_second", lastResult, 32'hBB);
    op(4, 0);
    chk("status_drained", lastResult, 32'h020);

    op(2, 32'hF);
    op(1, 32'd1);
    idle(40);
    op(4, 0);
    chk("overflow_status", {24'd0, lastResult[7:0]}, 32'hD0);
    op(1, 32'd0);
    op(5, 0);
    op(4, 0);
    chk("status_after_clear", lastResult, 32'h020);

    op(2, 32'h1);
    op(1, 32'd3);
    idle(3);
    op(3, 0);
    chk("pop_empty_during_push", lastResult, 32'd0);
    op(4, 0);
    chk("count_after_push", {27'd0, lastResult[4:0]}, 32'd1);

    op(2, 32'hF);
    op(1, 32'd2);
    idle(3);
    op(1, 32'd0);
    op(4, 0);
    chk("idle_after_abort", {30'd0, lastResult[9:8]}, 32'd0);
    idle(8);
    op(4, 0);
    op(5, 0);

    for (int i = 0; i < 2400; i++) begin
      if (i == 1200) doReset();
      popHeavy = (i % 800) >= 400;
      if ($urandom_range(0, 15) == 0) cvTable[$urandom_range(0, 3)] = $urandom();
      st = ($urandom_range(0, 99) < 45);
      ci = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : CID;
      k  = $urandom_range(0, 19);
      if (k < 2)       code = 0;
      else if (k < 4)  code = 1;
      else if (k < 6)  code = 2;
      else if (k < 11) code = 3;
      else if (k < 15) code = 4;
      else if (k == 15) code = 5;
      else code = $urandom_range(6, 15);
      if (code == 3 && !popHeavy && $urandom_range(0, 3) != 0) code = 4;
      b = $urandom();
      if (code == 1) b = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 10));
      cyc(st, ci, ($urandom() & 32'hFFFF_FFF0) | 32'(code), b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
